// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the CPU program sequencer: FSM encoding,
// the HALT opcode and the NOP word driven whenever nothing is issued.
package cpu_sequencer_pkg;

   localparam int CODE_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } seq_state_e;

   localparam logic [3:0]        OP_HALT  = 4'hE;
   localparam logic [CODE_W-1:0] CODE_NOP = 16'h0000;

   function automatic logic is_halt(input logic [CODE_W-1:0] word);
      return word[CODE_W-1 -: 4] == OP_HALT;
   endfunction

endpackage

// File: rtl/cpu_sequencer_prog_mem.sv
// Program store: DEPTH x 16 words, one synchronous write port, one
// asynchronous read port so the sequencer can decode mem[pc] in the same cycle.
module cpu_sequencer_prog_mem
   import cpu_sequencer_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [AW-1:0]     waddr_i,
   input  logic [CODE_W-1:0] wdata_i,
   input  logic [AW-1:0]     raddr_i,
   output logic [CODE_W-1:0] rdata_o
);

   logic [CODE_W-1:0] mem_q [DEPTH];

   // Contents deliberately survive reset so a program can be rerun.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cpu_sequencer.sv
// Streams a loaded program to a CPU one word per cycle: a one-cycle CPU clear,
// then issue with pause (NOP insertion), HALT detection, abort and end-of-program.
module cpu_sequencer
   import cpu_sequencer_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [CODE_W-1:0] wr_data,
   input  logic [AW-1:0]     last_addr,
   input  logic              start,
   input  logic              pause,
   input  logic              abort,
   output logic [CODE_W-1:0] code,
   output logic              cpu_clr,
   output logic [AW-1:0]     pc,
   output logic              busy,
   output logic              done,
   output logic              wr_err
);

   seq_state_e        state_q;
   logic [CODE_W-1:0] code_q;
   logic              cpu_clr_q;
   logic [AW-1:0]     pc_q;
   logic [AW-1:0]     last_q;
   logic              fin_q;
   logic              wr_err_q;

   logic              busy_d;
   logic              mem_we_d;
   logic [AW-1:0]     pc_inc_d;
   logic [CODE_W-1:0] word_d;

   assign busy_d   = (state_q == ST_CLEAR) || (state_q == ST_RUN);
   assign mem_we_d = wr_en && !clr && !busy_d;
   assign pc_inc_d = pc_q + AW'(1);

   cpu_sequencer_prog_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) prog_mem (
      .clk     (clk),
      .we_i    (mem_we_d),
      .waddr_i (wr_addr),
      .wdata_i (wr_data),
      .raddr_i (pc_q),
      .rdata_o (word_d)
   );

   // CLEAR and RUN share the issue path: the cycle leaving CLEAR already
   // presents word 0. fin_q marks that the last word went out, so DONE
   // appears one cycle later with code back at NOP.
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q   <= ST_IDLE;
         code_q    <= CODE_NOP;
         cpu_clr_q <= 1'b1;
         pc_q      <= '0;
         last_q    <= '0;
         fin_q     <= 1'b0;
         wr_err_q  <= 1'b0;
      end else begin
         code_q    <= CODE_NOP;
         cpu_clr_q <= 1'b0;
         wr_err_q  <= wr_en && busy_d;
         if (abort) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            fin_q   <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE, ST_DONE: begin
                  if (start) begin
                     state_q   <= ST_CLEAR;
                     last_q    <= last_addr;
                     pc_q      <= '0;
                     cpu_clr_q <= 1'b1;
                     fin_q     <= 1'b0;
                  end
               end
               ST_CLEAR, ST_RUN: begin
                  if (fin_q) begin
                     state_q <= ST_DONE;
                     fin_q   <= 1'b0;
                  end else begin
                     state_q <= ST_RUN;
                     if (!pause) begin
                        pc_q <= pc_inc_d;
                        if (is_halt(word_d)) begin
                           state_q <= ST_DONE;
                        end else begin
                           code_q <= word_d;
                           fin_q  <= (pc_q == last_q);
                        end
                     end
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign code    = code_q;
   assign cpu_clr = cpu_clr_q;
   assign pc      = pc_q;
   assign busy    = busy_d;
   assign done    = (state_q == ST_DONE);
   assign wr_err  = wr_err_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench: stimulus derives the expected per-cycle output from the
// program contents and pushes it tagged with the cycle it must appear in.
module tb_cpu_sequencer;

   logic        clk = 1'b0;
   logic        clr = 1'b1;
   logic        wr_en = 1'b0;
   logic [3:0]  wr_addr = '0;
   logic [15:0] wr_data = '0;
   logic [3:0]  last_addr = '0;
   logic        start = 1'b0;
   logic        pause = 1'b0;
   logic        abort = 1'b0;
   logic [15:0] code;
   logic        cpu_clr;
   logic [3:0]  pc;
   logic        busy;
   logic        done;
   logic        wr_err;

   cpu_sequencer #(.DEPTH(16), .AW(4)) dut (
      .clk       (clk),
      .clr       (clr),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .last_addr (last_addr),
      .start     (start),
      .pause     (pause),
      .abort     (abort),
      .code      (code),
      .cpu_clr   (cpu_clr),
      .pc        (pc),
      .busy      (busy),
      .done      (done),
      .wr_err    (wr_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic [15:0] code;
      logic [3:0]  pc;
      bit          busy;
      bit          done;
      bit          cpu_clr;
      bit          wr_err;
      logic [63:0] nm;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          cyc = 0;
   int          total = 0;
   int          bad = 0;
   logic [15:0] mdl_mem [16];
   logic [3:0]  idle_pc = '0;
   bit          idle_done = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         mon_e = exp_q.pop_front();
         total++;
         if (mon_e.cyc != cyc || code !== mon_e.code || pc !== mon_e.pc || busy !== mon_e.busy ||
             done !== mon_e.done || cpu_clr !== mon_e.cpu_clr || wr_err !== mon_e.wr_err) begin
            bad++;
            $display("FAIL %s cyc=%0d/%0d got code=%h pc=%0d busy=%b done=%b cpu_clr=%b wr_err=%b want code=%h pc=%0d busy=%b done=%b cpu_clr=%b wr_err=%b",
                     mon_e.nm, cyc, mon_e.cyc, code, pc, busy, done, cpu_clr, wr_err,
                     mon_e.code, mon_e.pc, mon_e.busy, mon_e.done, mon_e.cpu_clr, mon_e.wr_err);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [15:0] c, input logic [3:0] p, input bit b, input bit d,
                       input bit cc, input bit we, input logic [63:0] nm);
      exp_t e;
      e.cyc = cyc + 1; e.code = c; e.pc = p; e.busy = b; e.done = d;
      e.cpu_clr = cc; e.wr_err = we; e.nm = nm;
      exp_q.push_back(e);
   endtask

   function automatic logic [15:0] rnd_word(input int halt_pct);
      logic [15:0] w;
      w = 16'($urandom);
      if (int'($urandom_range(0, 99)) < halt_pct) w[15:12] = 4'hE;
      else if (w[15:12] == 4'hE) w[15:12] = 4'h1;
      return w;
   endfunction

   task automatic wr_word(input logic [3:0] ad, input logic [15:0] d);
      wr_en = 1'b1; wr_addr = ad; wr_data = d;
      mdl_mem[ad] = d;
      push(16'h0000, idle_pc, 1'b0, idle_done, 1'b0, 1'b0, "write");
      tick();
      wr_en = 1'b0;
   endtask

   // stop_at: loop cycle at which to abort (or clr when stop_clr); wr_at: cycle of a dropped write.
   task automatic run_prog(input logic [3:0] last, input int pause_pct, input logic [31:0] pmask,
                           input int stop_at, input bit stop_clr, input int wr_at);
      logic [15:0] words[$];
      bit          halted;
      bit          fin;
      bit          p;
      int          a;
      int          issued;
      logic [3:0]  npc;

      // What the program means: words from 0 up to HALT (not issued) or last (issued).
      a = 0; halted = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (mdl_mem[a][15:12] == 4'hE) begin
            halted = 1'b1;
            break;
         end
         words.push_back(mdl_mem[a]);
         if (a == int'(last)) break;
         a = (a + 1) % 16;
      end

      start = 1'b1; last_addr = last;
      push(16'h0000, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, "clear");
      tick();
      start = 1'b0; last_addr = 4'($urandom);

      npc = '0; issued = 0; fin = 1'b0;
      for (int k = 0; k < 200 && !fin; k++) begin
         if (k == stop_at) begin
            if (stop_clr) begin
               clr = 1'b1; start = 1'b1; pause = 1'b1;
               push(16'h0000, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, "clr_mid");
            end else begin
               abort = 1'b1; start = 1'b1; pause = 1'($urandom_range(0, 1));
               push(16'h0000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, "abort");
            end
            tick();
            clr = 1'b0; abort = 1'b0; start = 1'b0; pause = 1'b0;
            idle_pc = '0; idle_done = 1'b0;
            push(16'h0000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, "poststop");
            tick();
            return;
         end
         p = (k > 0) && ((k < 32 && pmask[k]) || int'($urandom_range(0, 99)) < pause_pct);
         pause = p;
         wr_en = (k == wr_at);
         if (wr_en) begin
            wr_addr = 4'($urandom); wr_data = 16'($urandom);
         end
         if (issued == words.size() && !halted) begin
            push(16'h0000, npc, 1'b0, 1'b1, 1'b0, wr_en, "done");
            fin = 1'b1;
         end else if (p) begin
            push(16'h0000, npc, 1'b1, 1'b0, 1'b0, wr_en, "pause");
         end else if (issued == words.size()) begin
            npc = npc + 4'd1;
            push(16'h0000, npc, 1'b0, 1'b1, 1'b0, wr_en, "halt");
            fin = 1'b1;
         end else begin
            npc = npc + 4'd1;
            push(words[issued], npc, 1'b1, 1'b0, 1'b0, wr_en, "issue");
            issued++;
         end
         tick();
         wr_en = 1'b0; pause = 1'b0;
      end
      idle_pc = npc; idle_done = 1'b1;
      push(16'h0000, npc, 1'b0, 1'b1, 1'b0, 1'b0, "hold");
      tick();
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mdl_mem[i] = '0;
      push(16'h0000, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, "reset");
      tick();
      push(16'h0000, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, "reset");
      tick();
      clr = 1'b0;
      push(16'h0000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, "rst_rel");
      tick();

      wr_word(4'd0, 16'h1000);
      wr_word(4'd1, 16'h1101);
      wr_word(4'd2, 16'h1203);
      run_prog(4'd2, 0, 32'h0, -1, 1'b0, -1);
      wr_word(4'd3, 16'hE000);
      run_prog(4'd7, 0, 32'h0, -1, 1'b0, -1);
      run_prog(4'd2, 0, 32'h1C, -1, 1'b0, -1);
      run_prog(4'd7, 0, 32'h0, 2, 1'b0, -1);
      run_prog(4'd2, 0, 32'h0, -1, 1'b0, 1);
      run_prog(4'd2, 0, 32'h0, -1, 1'b0, -1);

      for (int i = 0; i < 16; i++) wr_word(4'(i), rnd_word(0));
      run_prog(4'd15, 0, 32'h0, -1, 1'b0, -1);
      run_prog(4'd15, 0, 32'h0, 5, 1'b1, -1);

      for (int it = 0; it < 30; it++) begin
         for (int n = 0; n < int'($urandom_range(1, 6)); n++) wr_word(4'($urandom), rnd_word(10));
         run_prog(4'($urandom), int'($urandom_range(0, 35)), 32'h0,
                  ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 12)) : -1,
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : -1);
      end

      tick();
      tick();
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL leftover: %0d expected outputs never checked, want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
